// File: rtl/sample_uart_tx.sv
// Buffers filtered samples in a small FIFO and streams each one as two framed UART bytes.
// Define SAMPLE_UART_PARITY_EN for 8E1 framing (extra even-parity bit per byte); default is 8N1.
module sample_uart_tx #(
    parameter int DATA_IN_LEN     = 10,
    parameter int CLKS_PER_BIT    = 16,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_IN_LEN-1:0]     data_in,
    input  logic                       strobe_in,
    output logic                       tx_o,
    output logic                       busy_o,
    output logic                       overflow_o,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level_o
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int BW    = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]            BAUD_MAX   = BW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] LEVEL_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SAMPLE_UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state, state_next;

    logic [DATA_IN_LEN-1:0]   mem [DEPTH];
    logic [FIFO_DEPTH_LOG2:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next, level;
    logic                     full, empty, pop, wr_en, drop;
    logic [13:0]              rd_sample;

    logic [BW-1:0] baud_cnt, baud_next;
    logic [2:0]    bit_cnt, bit_next;
    logic [7:0]    shift_q, shift_next;
    logic [6:0]    low_q, low_next;
    logic          byte_sel, byte_sel_next;
    logic          tx_next;
    logic          baud_done;
`ifdef SAMPLE_UART_PARITY_EN
    logic          parity_q, parity_next;
`endif

    // Extra wrap bit makes equal low bits with differing wrap bits read as full.
    assign level     = wr_ptr - rd_ptr;
    assign full      = (level == LEVEL_FULL);
    assign empty     = (level == '0);
    assign rd_sample = 14'(mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]]);
    assign baud_done = (baud_cnt == BAUD_MAX);

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
    always_comb begin
        wr_en       = strobe_in && (!full || pop);
        drop        = strobe_in && full && !pop;
        wr_ptr_next = wr_en ? wr_ptr + 1'b1 : wr_ptr;
        rd_ptr_next = pop   ? rd_ptr + 1'b1 : rd_ptr;
    end

    always_comb begin
        state_next    = state;
        baud_next     = baud_cnt;
        bit_next      = bit_cnt;
        shift_next    = shift_q;
        low_next      = low_q;
        byte_sel_next = byte_sel;
        tx_next       = tx_o;
        pop           = 1'b0;
`ifdef SAMPLE_UART_PARITY_EN
        parity_next   = parity_q;
`endif
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop           = 1'b1;
                    shift_next    = {1'b1, rd_sample[13:7]};
                    low_next      = rd_sample[6:0];
                    byte_sel_next = 1'b0;
                    baud_next     = '0;
                    tx_next       = 1'b0;
                    state_next    = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    tx_next    = shift_q[0];
                    state_next = DATA;
`ifdef SAMPLE_UART_PARITY_EN
                    parity_next = 1'b0;
`endif
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next = '0;
`ifdef SAMPLE_UART_PARITY_EN
                    parity_next = parity_q ^ tx_o;
`endif
                    if (bit_cnt == 3'd7) begin
`ifdef SAMPLE_UART_PARITY_EN
                        tx_next    = parity_q ^ tx_o;
                        state_next = PARITY;
`else
                        tx_next    = 1'b1;
                        state_next = STOP;
`endif
                    end else begin
                        bit_next   = bit_cnt + 3'd1;
                        shift_next = {1'b0, shift_q[7:1]};
                        tx_next    = shift_q[1];
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
`ifdef SAMPLE_UART_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    baud_next  = '0;
                    tx_next    = 1'b1;
                    state_next = STOP;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (!byte_sel) begin
                        shift_next    = {1'b0, low_q};
                        byte_sel_next = 1'b1;
                        tx_next       = 1'b0;
                        state_next    = START;
                    end else if (!empty) begin
                        pop           = 1'b1;
                        shift_next    = {1'b1, rd_sample[13:7]};
                        low_next      = rd_sample[6:0];
                        byte_sel_next = 1'b0;
                        tx_next       = 1'b0;
                        state_next    = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= data_in;
        end
    end

    // Status outputs are registered from next-state values so they align with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            shift_q      <= '0;
            low_q        <= '0;
            byte_sel     <= 1'b0;
            tx_o         <= 1'b1;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level_o <= '0;
            busy_o       <= 1'b0;
            overflow_o   <= 1'b0;
`ifdef SAMPLE_UART_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            baud_cnt     <= baud_next;
            bit_cnt      <= bit_next;
            shift_q      <= shift_next;
            low_q        <= low_next;
            byte_sel     <= byte_sel_next;
            tx_o         <= tx_next;
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            fifo_level_o <= wr_ptr_next - rd_ptr_next;
            busy_o       <= (state_next != IDLE) || (wr_ptr_next != rd_ptr_next);
            if (drop) begin
                overflow_o <= 1'b1;
            end
`ifdef SAMPLE_UART_PARITY_EN
            parity_q     <= parity_next;
`endif
        end
    end

endmodule

// File: tb/tb_sample_uart_tx.sv
// Scoreboard bench for sample_uart_tx: expected bytes are queued at stimulus time and
// compared against bytes decoded from the serial line.
module tb_sample_uart_tx;

    localparam int CPB  = 4;
    localparam int DW   = 10;
    localparam int LOG2 = 2;
`ifdef SAMPLE_UART_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int FRAME = 2 * BITS * CPB;

    logic          clk;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          strobe_in;
    logic          tx_o;
    logic          busy_o;
    logic          overflow_o;
    logic [LOG2:0] fifo_level_o;

    sample_uart_tx #(
        .DATA_IN_LEN    (DW),
        .CLKS_PER_BIT   (CPB),
        .FIFO_DEPTH_LOG2(LOG2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .strobe_in   (strobe_in),
        .tx_o        (tx_o),
        .busy_o      (busy_o),
        .overflow_o  (overflow_o),
        .fifo_level_o(fifo_level_o)
    );

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         start;
    } rx_t;

    rx_t        rx_q[$];
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Line decoder: samples each bit mid-period and queues every completed byte.
    bit  mon_active = 1'b0;
    int  mcnt;
    int  idx;
    rx_t cur;
    always @(negedge clk) begin
        if (reset) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx_o === 1'b0) begin
                mon_active = 1'b1;
                mcnt       = 0;
                cur.data   = '0;
                cur.par    = 1'b0;
                cur.stop   = 1'b0;
                cur.start  = cyc;
            end
        end else begin
            mcnt++;
            if (mcnt % CPB == CPB / 2) begin
                idx = mcnt / CPB;
                if (idx >= 1 && idx <= 8) begin
                    cur.data[idx-1] = tx_o;
                end else if (idx == BITS - 1) begin
                    cur.stop = tx_o;
                    rx_q.push_back(cur);
                    mon_active = 1'b0;
                end else begin
                    cur.par = tx_o;
                end
            end
        end
    end

    task automatic push_sample(input logic [DW-1:0] d);
        logic [13:0] x;
        x = 14'(d);
        exp_q.push_back({1'b1, x[13:7]});
        exp_q.push_back({1'b0, x[6:0]});
    endtask

    task automatic drive_sample(input logic [DW-1:0] d, input bit accept);
        data_in   = d;
        strobe_in = 1'b1;
        if (accept) push_sample(d);
        @(negedge clk);
        strobe_in = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        strobe_in = 1'b0;
        data_in   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (busy_o === 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (tx_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx got %b expected 1", tx_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b expected 0", overflow_o); end
        checks++; if (fifo_level_o !== '0) begin errors++; $display("[TB] FAIL reset_level got %0d expected 0", fifo_level_o); end
    endtask

    task automatic test_single();
        int         kcyc, n, i, prev;
        logic [7:0] e;
        rx_t        r;
        do_reset();
        drive_sample(10'h3A5, 1'b1);
        kcyc = cyc;
        checks++; if (fifo_level_o !== 3'd1) begin errors++; $display("[TB] FAIL single_level_k got %0d expected 1", fifo_level_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_k got %b expected 1", busy_o); end
        checks++; if (tx_o !== 1'b1) begin errors++; $display("[TB] FAIL single_tx_k got %b expected 1", tx_o); end
        @(negedge clk);
        checks++; if (fifo_level_o !== 3'd0) begin errors++; $display("[TB] FAIL single_level_k1 got %0d expected 0", fifo_level_o); end
        checks++; if (tx_o !== 1'b0) begin errors++; $display("[TB] FAIL single_start_bit got %b expected 0", tx_o); end
        wait_idle(FRAME * 2, n);
        checks++; if (n != FRAME) begin errors++; $display("[TB] FAIL single_busy_len got %0d expected %0d", n, FRAME); end
        repeat (2) @(negedge clk);
        i = 0; prev = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0) begin
                errors++; $display("[TB] FAIL single_byte%0d got none expected %02h", i, e);
            end else begin
                r = rx_q.pop_front();
                if (r.data !== e) begin errors++; $display("[TB] FAIL single_byte%0d got %02h expected %02h", i, r.data, e); end
                checks++; if (r.stop !== 1'b1) begin errors++; $display("[TB] FAIL single_stop%0d got %b expected 1", i, r.stop); end
`ifdef SAMPLE_UART_PARITY_EN
                checks++; if (r.par !== ^e) begin errors++; $display("[TB] FAIL single_parity%0d got %b expected %b", i, r.par, ^e); end
`endif
                checks++;
                if (i == 0 && r.start != kcyc + 1) begin
                    errors++; $display("[TB] FAIL single_start_time got %0d expected %0d", r.start, kcyc + 1);
                end else if (i > 0 && r.start - prev != FRAME / 2) begin
                    errors++; $display("[TB] FAIL single_spacing got %0d expected %0d", r.start - prev, FRAME / 2);
                end
                prev = r.start;
            end
            i++;
        end
        checks++; if (rx_q.size() != 0) begin errors++; $display("[TB] FAIL single_extra got %0d expected 0", rx_q.size()); end
    endtask

    task automatic test_back_to_back();
        int         kcyc, n, i, prev, peak;
        logic [7:0] e;
        rx_t        r;
        do_reset();
        peak = 0;
        drive_sample(10'h001, 1'b1);
        kcyc = cyc;
        if (int'(fifo_level_o) > peak) peak = int'(fifo_level_o);
        @(negedge clk);
        if (int'(fifo_level_o) > peak) peak = int'(fifo_level_o);
        drive_sample(10'h3FF, 1'b1);
        if (int'(fifo_level_o) > peak) peak = int'(fifo_level_o);
        checks++; if (peak != 1) begin errors++; $display("[TB] FAIL b2b_peak_level got %0d expected 1", peak); end
        wait_idle(FRAME * 4, n);
        checks++; if (n != 2 * FRAME - 1) begin errors++; $display("[TB] FAIL b2b_busy_len got %0d expected %0d", n, 2 * FRAME - 1); end
        repeat (2) @(negedge clk);
        i = 0; prev = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0) begin
                errors++; $display("[TB] FAIL b2b_byte%0d got none expected %02h", i, e);
            end else begin
                r = rx_q.pop_front();
                if (r.data !== e) begin errors++; $display("[TB] FAIL b2b_byte%0d got %02h expected %02h", i, r.data, e); end
                checks++; if (r.stop !== 1'b1) begin errors++; $display("[TB] FAIL b2b_stop%0d got %b expected 1", i, r.stop); end
                checks++;
                if (i == 0 && r.start != kcyc + 1) begin
                    errors++; $display("[TB] FAIL b2b_start_time got %0d expected %0d", r.start, kcyc + 1);
                end else if (i > 0 && r.start - prev != FRAME / 2) begin
                    errors++; $display("[TB] FAIL b2b_gap%0d got %0d expected %0d", i, r.start - prev, FRAME / 2);
                end
                prev = r.start;
            end
            i++;
        end
        checks++; if (rx_q.size() != 0) begin errors++; $display("[TB] FAIL b2b_extra got %0d expected 0", rx_q.size()); end
    endtask

    task automatic test_overflow();
        int         n, i;
        logic [7:0] e;
        rx_t        r;
        do_reset();
        for (int k = 0; k < 5; k++) drive_sample(DW'(k * 100 + 7), 1'b1);
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early got %b expected 0", overflow_o); end
        checks++; if (fifo_level_o !== 3'd4) begin errors++; $display("[TB] FAIL ovf_full_level got %0d expected 4", fifo_level_o); end
        drive_sample(DW'(507), 1'b0);
        checks++; if (fifo_level_o !== 3'd4) begin errors++; $display("[TB] FAIL ovf_level got %0d expected 4", fifo_level_o); end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %b expected 1", overflow_o); end
        wait_idle(FRAME * 8, n);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf_timeout got busy %b expected 0", busy_o); end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got %b expected 1", overflow_o); end
        repeat (2) @(negedge clk);
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0) begin
                errors++; $display("[TB] FAIL ovf_byte%0d got none expected %02h", i, e);
            end else begin
                r = rx_q.pop_front();
                if (r.data !== e) begin errors++; $display("[TB] FAIL ovf_byte%0d got %02h expected %02h", i, r.data, e); end
            end
            i++;
        end
        checks++; if (rx_q.size() != 0) begin errors++; $display("[TB] FAIL ovf_extra got %0d expected 0", rx_q.size()); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear got %b expected 0", overflow_o); end
    endtask

    task automatic test_full_pop();
        int         n, i;
        logic [7:0] e;
        rx_t        r;
        do_reset();
        drive_sample(10'h155, 1'b1);
        repeat (49) @(negedge clk);
        for (int k = 0; k < 4; k++) drive_sample(DW'(10'h200 + k), 1'b1);
        repeat (FRAME - 53) @(negedge clk);
        checks++; if (fifo_level_o !== 3'd4) begin errors++; $display("[TB] FAIL fullpop_pre_level got %0d expected 4", fifo_level_o); end
        drive_sample(10'h0AA, 1'b1);
        checks++; if (fifo_level_o !== 3'd4) begin errors++; $display("[TB] FAIL fullpop_level got %0d expected 4", fifo_level_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_overflow got %b expected 0", overflow_o); end
        checks++; if (tx_o !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_start got %b expected 0", tx_o); end
        wait_idle(FRAME * 8, n);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_timeout got busy %b expected 0", busy_o); end
        repeat (2) @(negedge clk);
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0) begin
                errors++; $display("[TB] FAIL fullpop_byte%0d got none expected %02h", i, e);
            end else begin
                r = rx_q.pop_front();
                if (r.data !== e) begin errors++; $display("[TB] FAIL fullpop_byte%0d got %02h expected %02h", i, r.data, e); end
            end
            i++;
        end
        checks++; if (rx_q.size() != 0) begin errors++; $display("[TB] FAIL fullpop_extra got %0d expected 0", rx_q.size()); end
    endtask

    task automatic test_reset_midframe();
        int         n, i;
        logic [7:0] e;
        rx_t        r;
        do_reset();
        drive_sample(10'h2C3, 1'b1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (tx_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_tx got %b expected 1", tx_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b expected 0", busy_o); end
        checks++; if (fifo_level_o !== 3'd0) begin errors++; $display("[TB] FAIL midrst_level got %0d expected 0", fifo_level_o); end
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        rx_q.delete();
        drive_sample(10'h0F0, 1'b1);
        wait_idle(FRAME * 2, n);
        checks++; if (n != FRAME + 1) begin errors++; $display("[TB] FAIL midrst_busy_len got %0d expected %0d", n, FRAME + 1); end
        repeat (2) @(negedge clk);
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0) begin
                errors++; $display("[TB] FAIL midrst_byte%0d got none expected %02h", i, e);
            end else begin
                r = rx_q.pop_front();
                if (r.data !== e) begin errors++; $display("[TB] FAIL midrst_byte%0d got %02h expected %02h", i, r.data, e); end
            end
            i++;
        end
        checks++; if (rx_q.size() != 0) begin errors++; $display("[TB] FAIL midrst_extra got %0d expected 0", rx_q.size()); end
    endtask

    initial begin
        reset     = 1'b1;
        strobe_in = 1'b0;
        data_in   = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_uart_tx.md
# sample_uart_tx

Downstream consumer of the moving-average filter stage: takes each filtered sample (`data_in` with one-cycle `strobe_in`), buffers it in a small FIFO, and streams it off-chip as two framed UART bytes on a single pin. It sits after the filter-select output register and decouples the filter's burst strobe rate from the slow serial link. Overflow is flagged rather than back-pressured, because the filter has no stall input.

## Interface
- `DATA_IN_LEN`, 10: sample width; legal range 8..14.
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; minimum 2.
- `FIFO_DEPTH_LOG2`, 2: FIFO holds 2^N samples (default 4).

- `clk`  in  1  clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  DATA_IN_LEN  filtered sample; valid only when `strobe_in`=1.
- `strobe_in`  in  1  one-cycle sample-valid pulse.
- `tx_o`  out  1  UART line; idle high.
- `busy_o`  out  1  high while FSM is not IDLE or FIFO is non-empty.
- `overflow_o`  out  1  sticky; set when a sample is dropped.
- `fifo_level_o`  out  FIFO_DEPTH_LOG2+1  number of samples currently stored.

## Operation
- Sample framing: zero-extend `data_in` to 14 bits as `d`.
  - Byte 0 (sync byte) = {1'b1, d[13:7]}.
  - Byte 1 = {1'b0, d[6:0]}.
  - Bit 7 marks the sync byte, so a receiver can realign after lost bytes.
- UART format: 8N1, LSB first, start bit 0, stop bit 1.
- FIFO write: on `strobe_in`=1, `data_in` is written if the FIFO is not full.
  - If full and no pop occurs in the same cycle: the sample is dropped, the FIFO is unchanged, and `overflow_o` is set.
  - If full and a pop occurs in the same cycle: the write is accepted.
- FSM states: IDLE, START, DATA, STOP; a `byte_sel` flag selects byte 0 or byte 1.
  - IDLE: if FIFO non-empty, pop, load byte 0 into the shift register, go to START.
  - START: `tx_o`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: shift out 8 bits, each CLKS_PER_BIT cycles, then STOP.
  - STOP: `tx_o`=1 for CLKS_PER_BIT cycles. Next state:
    - `byte_sel`=0: load byte 1, go to START.
    - `byte_sel`=1 and FIFO non-empty: pop, load byte 0, go to START (no idle gap).
    - Otherwise: go to IDLE.
- Reset (also mid-frame):
  - FIFO emptied, FSM to IDLE, bit and baud counters cleared.
  - Outputs: `tx_o`=1, `busy_o`=0, `overflow_o`=0, `fifo_level_o`=0.
  - A truncated frame on the line is acceptable.
- Pointers wrap modulo 2^FIFO_DEPTH_LOG2. `fifo_level_o` is derived from an extra-bit pointer difference, so it reads full (= depth) when pointers are equal and the wrap bits differ.

## Timing
- Define edge k as the clock edge at which `strobe_in`=1 is sampled with the FIFO empty and the FSM in IDLE.
  - Edge k: write; `fifo_level_o`=1.
  - Edge k+1: pop; `fifo_level_o`=0; `tx_o`=0 (start bit of byte 0).
- One sample frame lasts exactly 20·CLKS_PER_BIT cycles; back-to-back samples add no gap.
- All outputs are registered; no combinational path from inputs to `tx_o`.
- `busy_o` rises after edge k and falls after the final stop-bit cycle of the last queued sample.
- `overflow_o` is updated at the dropping edge and clears only on `reset`.

## Configuration
- `SAMPLE_UART_PARITY_EN`
  - Defined: 8E1 format. An even-parity bit over the 8 data bits is inserted between DATA and STOP via an added PARITY state; frame = 22·CLKS_PER_BIT cycles per sample.
  - Undefined: 8N1 as above; the PARITY state and its logic are absent.

## Test plan
All scenarios use CLKS_PER_BIT=4 and the default depth.
- Single sample: `data_in`=10'h3A5 strobed from idle → line carries byte 0x87 then 0x25, LSB first, start bit at edge k+1; `busy_o` low exactly 80 cycles after edge k+1.
- Back-to-back: strobe 10'h001 then 10'h3FF, 2 cycles apart → bytes 0x80, 0x01, 0x87, 0x7F with no idle gap; `fifo_level_o` peaks at 1.
- Overflow: 6 strobes within 6 cycles from idle → first 5 accepted (1 popped, 4 stored), 6th dropped; `overflow_o`=1 and stays 1 until `reset`.
- Full + pop same cycle: fill FIFO to 4 during byte 1 of a sample, then strobe on the STOP→START pop edge → write accepted, `overflow_o` stays 0.
- Reset mid-frame: assert `reset` during DATA of byte 0 → next cycle `tx_o`=1, `busy_o`=0, `fifo_level_o`=0; a new strobe afterwards transmits normally.
- With `SAMPLE_UART_PARITY_EN`: 10'h3A5 → parity bits 0 (for 0x87) and 1 (for 0x25); frame is 88 cycles.
